// File: rtl/memctrl_pkg.sv
// memctrl_pkg: shared constants and types for the memory controller.
// Holds the default width, depth and latency values used as parameter
// defaults by memory_controller, and the address/data return struct.
package memctrl_pkg;

    localparam int unsigned DefAddrW = 16;
    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefDepth = 1024;
    localparam int unsigned DefRdLat = 2;
    localparam int unsigned DefWrLat = 1;

    // Return beat at the default widths: echoed address plus data.
    typedef struct packed {
        logic [DefAddrW-1:0] addr;
        logic [DefDataW-1:0] data;
    } ret_t;

endpackage

// File: rtl/memctrl_pipe.sv
// memctrl_pipe: valid+payload delay line of LAT register stages.
// A beat presented at edge k appears on out_valid/out_data after edge
// k+LAT-1. Payload is forced to zero for invalid beats so the output is
// zero whenever out_valid is low. Synchronous active-high reset clears
// every stage and drops the beat presented at that edge.
// Ports:
//   clk, reset         clock and synchronous reset
//   in_valid, in_data  beat entering the line
//   out_valid, out_data beat leaving the line
module memctrl_pipe #(
    parameter int unsigned LAT = 1,
    parameter int unsigned W   = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [LAT-1:0] valid_q, valid_d;
    logic [W-1:0]   data_q [LAT];
    logic [W-1:0]   data_d [LAT];

    always_comb begin
        valid_d    = valid_q;
        valid_d[0] = in_valid;
        data_d     = data_q;
        data_d[0]  = in_valid ? in_data : '0;
        for (int i = 1; i < int'(LAT); i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < int'(LAT); i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_data  = data_q[LAT-1];

endmodule

// File: rtl/memory_controller.sv
// memory_controller: single-port-per-direction storage with fixed-latency
// acknowledged reads and writes, one of each accepted per cycle, no
// backpressure. Storage is indexed by the low log2(DEPTH) address bits;
// the full address is echoed on return. Storage is not cleared by reset.
// Optional build macro MEMCTRL_FWD_EN: a same-edge read and write to the
// same index returns the new write data instead of the old contents.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   wr_address, wr_en, wr_data          write request
//   wr_ret_address, wr_ret_ack          write acknowledge (WR_LAT edges)
//   rd_address, rd_en                   read request
//   rd_ret_data, rd_ret_address, rd_ret_ack  read return (RD_LAT edges)
module memory_controller
    import memctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned RD_LAT = DefRdLat,
    parameter int unsigned WR_LAT = DefWrLat
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_ret_address,
    output logic              wr_ret_ack,
    input  logic [ADDR_W-1:0] rd_address,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_ret_data,
    output logic [ADDR_W-1:0] rd_ret_address,
    output logic              rd_ret_ack
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [IdxW-1:0]   wr_idx;
    logic [IdxW-1:0]   rd_idx;
    logic [DATA_W-1:0] rd_sample;

    assign wr_idx = wr_address[IdxW-1:0];
    assign rd_idx = rd_address[IdxW-1:0];

    // Reads sample the array before this edge's write lands, which gives
    // read-before-write unless forwarding is built in.
    always_comb begin
        rd_sample = mem_q[rd_idx];
`ifdef MEMCTRL_FWD_EN
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_sample = wr_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    logic [ADDR_W+DATA_W-1:0] rd_beat_in;
    logic [ADDR_W+DATA_W-1:0] rd_beat_out;

    assign rd_beat_in = {rd_address, rd_sample};

    memctrl_pipe #(
        .LAT (RD_LAT),
        .W   (ADDR_W + DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_en),
        .in_data   (rd_beat_in),
        .out_valid (rd_ret_ack),
        .out_data  (rd_beat_out)
    );

    assign rd_ret_address = rd_beat_out[ADDR_W+DATA_W-1:DATA_W];
    assign rd_ret_data    = rd_beat_out[DATA_W-1:0];

    memctrl_pipe #(
        .LAT (WR_LAT),
        .W   (ADDR_W)
    ) u_wr_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (wr_en),
        .in_data   (wr_address),
        .out_valid (wr_ret_ack),
        .out_data  (wr_ret_address)
    );

endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: directed self-checking bench for memory_controller
// at default parameters (ADDR_W=16, DATA_W=16, DEPTH=1024, RD_LAT=2,
// WR_LAT=1). Inputs change 1 time unit after a rising edge; outputs are
// sampled at that same point, so they reflect the edge just taken.
module tb_memory_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] wr_address;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] wr_ret_address;
    logic        wr_ret_ack;
    logic [15:0] rd_address;
    logic        rd_en;
    logic [15:0] rd_ret_data;
    logic [15:0] rd_ret_address;
    logic        rd_ret_ack;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    memory_controller dut (
        .clk            (clk),
        .reset          (reset),
        .wr_address     (wr_address),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .wr_ret_address (wr_ret_address),
        .wr_ret_ack     (wr_ret_ack),
        .rd_address     (rd_address),
        .rd_en          (rd_en),
        .rd_ret_data    (rd_ret_data),
        .rd_ret_address (rd_ret_address),
        .rd_ret_ack     (rd_ret_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en      = 1'b0;
        wr_address = '0;
        wr_data    = '0;
        rd_en      = 1'b0;
        rd_address = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " wr_ack"},  {31'd0, wr_ret_ack}, 32'd0);
        chk({tag, " wr_addr"}, {16'd0, wr_ret_address}, 32'd0);
        chk({tag, " rd_ack"},  {31'd0, rd_ret_ack}, 32'd0);
        chk({tag, " rd_addr"}, {16'd0, rd_ret_address}, 32'd0);
        chk({tag, " rd_data"}, {16'd0, rd_ret_data}, 32'd0);
    endtask

    logic [15:0] fwd_exp;
    int          wr_acks;
    int          rd_acks;

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;

        // Single write, ack one cycle later, exactly one pulse.
        wr_en = 1'b1; wr_address = 16'h0005; wr_data = 16'h1234;
        tick();
        idle();
        chk("wr1 ack",  {31'd0, wr_ret_ack}, 32'd1);
        chk("wr1 addr", {16'd0, wr_ret_address}, 32'h0005);
        tick();
        chk("wr1 ack drop", {31'd0, wr_ret_ack}, 32'd0);
        chk("wr1 addr zero", {16'd0, wr_ret_address}, 32'd0);

        // Read back, ack two edges after acceptance.
        rd_en = 1'b1; rd_address = 16'h0005;
        tick();
        idle();
        chk("rd1 early", {31'd0, rd_ret_ack}, 32'd0);
        tick();
        chk("rd1 ack",  {31'd0, rd_ret_ack}, 32'd1);
        chk("rd1 addr", {16'd0, rd_ret_address}, 32'h0005);
        chk("rd1 data", {16'd0, rd_ret_data}, 32'h1234);
        tick();
        chk_all_zero("rd1 after");

        // Streamed writes to 150..169 with reads of 0..19 alongside.
        wr_acks = 0;
        rd_acks = 0;
        for (int c = 0; c < 22; c++) begin
            if (c < 20) begin
                wr_en = 1'b1; wr_address = 16'(150 + c); wr_data = 16'(c);
                rd_en = 1'b1; rd_address = 16'(c);
            end else begin
                idle();
            end
            tick();
            if (c < 20) begin
                chk("strw ack",  {31'd0, wr_ret_ack}, 32'd1);
                chk("strw addr", {16'd0, wr_ret_address}, 32'(150 + c));
                if (wr_ret_ack) wr_acks++;
            end
            if (c >= 1 && c <= 20) begin
                chk("strr0 ack",  {31'd0, rd_ret_ack}, 32'd1);
                chk("strr0 addr", {16'd0, rd_ret_address}, 32'(c - 1));
                if (rd_ret_ack) rd_acks++;
            end
        end
        chk("strw count", 32'(wr_acks), 32'd20);
        chk("strr0 count", 32'(rd_acks), 32'd20);
        chk_all_zero("stream idle");

        // Read 150..169 back in order.
        rd_acks = 0;
        for (int c = 0; c < 21; c++) begin
            if (c < 20) begin
                rd_en = 1'b1; rd_address = 16'(150 + c);
            end else begin
                idle();
            end
            tick();
            if (c >= 1) begin
                chk("strr1 ack",  {31'd0, rd_ret_ack}, 32'd1);
                chk("strr1 addr", {16'd0, rd_ret_address}, 32'(150 + c - 1));
                chk("strr1 data", {16'd0, rd_ret_data}, 32'(c - 1));
                if (rd_ret_ack) rd_acks++;
            end
        end
        idle();
        tick();
        chk("strr1 count", 32'(rd_acks), 32'd20);
        chk_all_zero("strr1 idle");

        // Same-edge read and write to 0x0010 holding 0x0001.
        wr_en = 1'b1; wr_address = 16'h0010; wr_data = 16'h0001;
        tick();
        wr_en = 1'b1; wr_address = 16'h0010; wr_data = 16'hBEEF;
        rd_en = 1'b1; rd_address = 16'h0010;
        tick();
        idle();
        tick();
`ifdef MEMCTRL_FWD_EN
        fwd_exp = 16'hBEEF;
`else
        fwd_exp = 16'h0001;
`endif
        chk("rw same ack",  {31'd0, rd_ret_ack}, 32'd1);
        chk("rw same data", {16'd0, rd_ret_data}, {16'd0, fwd_exp});
        rd_en = 1'b1; rd_address = 16'h0010;
        tick();
        idle();
        tick();
        chk("rw after data", {16'd0, rd_ret_data}, 32'h0000BEEF);

        // Reset one cycle after a read: the read is dropped, and a write
        // presented on the reset edge is ignored.
        rd_en = 1'b1; rd_address = 16'h0005;
        tick();
        idle();
        reset = 1'b1;
        wr_en = 1'b1; wr_address = 16'h0005; wr_data = 16'h5555;
        tick();
        idle();
        reset = 1'b0;
        chk_all_zero("mid reset");
        tick();
        chk_all_zero("post reset");
        rd_en = 1'b1; rd_address = 16'h0005;
        tick();
        idle();
        tick();
        chk("retain ack",  {31'd0, rd_ret_ack}, 32'd1);
        chk("retain data", {16'd0, rd_ret_data}, 32'h1234);

        // Aliasing: 0x0405 maps to index 5 with DEPTH=1024.
        wr_en = 1'b1; wr_address = 16'h0405; wr_data = 16'hA5A5;
        tick();
        idle();
        chk("alias wr addr", {16'd0, wr_ret_address}, 32'h0405);
        rd_en = 1'b1; rd_address = 16'h0005;
        tick();
        idle();
        tick();
        chk("alias ack",  {31'd0, rd_ret_ack}, 32'd1);
        chk("alias addr", {16'd0, rd_ret_address}, 32'h0005);
        chk("alias data", {16'd0, rd_ret_data}, 32'h0000A5A5);
        tick();
        chk_all_zero("final idle");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, request/return address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, data width.
REQ-003 The block SHALL have parameter DEPTH, default 1024, number of storage words, a power of two no greater than 2**ADDR_W.
REQ-004 The block SHALL have parameter RD_LAT, default 2, read latency in clock edges, minimum 1.
REQ-005 The block SHALL have parameter WR_LAT, default 1, write-acknowledge latency in clock edges, minimum 1.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-008 The block SHALL have port wr_address, input, ADDR_W bits, write request address.
REQ-009 The block SHALL have port wr_en, input, 1 bit, write request valid.
REQ-010 The block SHALL have port wr_data, input, DATA_W bits, write request data.
REQ-011 The block SHALL have port wr_ret_address, output, ADDR_W bits, echoed address of the acknowledged write.
REQ-012 The block SHALL have port wr_ret_ack, output, 1 bit, one-cycle write-completion pulse.
REQ-013 The block SHALL have port rd_address, input, ADDR_W bits, read request address.
REQ-014 The block SHALL have port rd_en, input, 1 bit, read request valid.
REQ-015 The block SHALL have port rd_ret_data, output, DATA_W bits, returned read data.
REQ-016 The block SHALL have port rd_ret_address, output, ADDR_W bits, echoed address of the returned read.
REQ-017 The block SHALL have port rd_ret_ack, output, 1 bit, one-cycle read-return pulse.

Function
REQ-018 The block SHALL accept one read and one write on every rising edge where the matching enable is high and reset is low; there is no backpressure and no ready signal.
REQ-019 Storage SHALL be indexed by address modulo DEPTH (low log2(DEPTH) bits); the full ADDR_W-bit address SHALL be echoed on return.
REQ-020 A write accepted at edge k SHALL update storage at edge k.
REQ-021 A write accepted at edge k SHALL raise wr_ret_ack with wr_ret_address for exactly one cycle after edge k+WR_LAT-1.
REQ-022 A read accepted at edge k SHALL sample storage at edge k and raise rd_ret_ack, rd_ret_address and rd_ret_data for exactly one cycle after edge k+RD_LAT-1.
REQ-023 Returns SHALL be in request order; back-to-back requests SHALL give back-to-back acks.
REQ-024 A read and a write to the same index at the same edge SHALL return the old data (read-before-write), unless REQ-030 applies.
REQ-025 rd_ret_data, rd_ret_address and wr_ret_address SHALL be zero whenever the corresponding ack is low.
REQ-026 Reading a never-written index SHALL return an unspecified value; this is not an error.

Reset
REQ-027 While reset is high at an edge, the block SHALL clear all in-flight pipeline entries, drive every output to zero from the next cycle, and ignore any request presented at that edge.
REQ-028 Reset mid-operation SHALL drop all in-flight acks; writes already committed SHALL remain in storage, because storage contents are not cleared by reset.

Configuration
REQ-029 The block SHALL support the macro MEMCTRL_FWD_EN, which selects same-cycle read/write forwarding.
REQ-030 With MEMCTRL_FWD_EN defined, a read and a write to the same index at the same edge SHALL return the new write data.
REQ-031 Without MEMCTRL_FWD_EN, REQ-024 (old data) SHALL hold.

Structure
REQ-032 The shared package memctrl_pkg SHALL hold the default width, depth and latency constants and an address/data return struct typedef.
REQ-033 The block SHALL use one sub-module, memctrl_pipe, a parameterised valid+payload delay line with synchronous reset, instantiated once for the read path and once for the write path.

Verification
REQ-034 Bench SHALL drive reset for 2 cycles, then a single write of 0x1234 to 0x0005 -> exactly one wr_ret_ack pulse, 1 cycle later, with wr_ret_address=0x0005.
REQ-035 Bench SHALL issue a read of 0x0005 after REQ-034 -> rd_ret_ack pulses 2 cycles later with rd_ret_address=0x0005 and rd_ret_data=0x1234.
REQ-036 Bench SHALL issue a stream of 20 cycles of writes to 150..169 with data 0..19, alongside reads of 0..19, then reads of 150..169 -> 20 consecutive acks each, with data at address 150+i equal to i, in order.
REQ-037 Bench SHALL issue a same-edge write of 0xBEEF and read of 0x0010 when the location holds 0x0001 -> return 0x0001 without MEMCTRL_FWD_EN and 0xBEEF with it.
REQ-038 Bench SHALL assert reset one cycle after a read is issued -> no rd_ret_ack and all outputs zero.
REQ-039 Bench SHALL write address 0x0405 with DEPTH=1024, then read 0x0005 -> aliased data returned and rd_ret_address=0x0005.
